// File: rtl/axil_bram_pkg.sv
// Shared definitions for the AXI4-Lite to BRAM bridge.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   state_t                 : bridge FSM states
//   PRIO_READ / PRIO_WRITE  : round-robin priority values
//   clog2()                 : elaboration-time ceiling log2
package axil_bram_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic PRIO_READ  = 1'b0;
   localparam logic PRIO_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_RESP  = 3'd2,
      WR_DATA  = 3'd3,
      WR_ISSUE = 3'd4,
      WR_RESP  = 3'd5
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/axil_bram_bridge_if.sv
// AXI4-Lite slave channel bundle (AR, R, AW, W, B).
//   slave  modport : used by the bridge (inputs = valid/addr/data/ready from the bus)
//   master modport : used by whoever drives the bus (interconnect or bench)
interface axil_bram_bridge_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axil_rr_arb2.sv
// Two-requester round-robin arbiter: req[0] = read, req[1] = write.
//   clk, rstn : clock, synchronous active-low reset (priority returns to read)
//   req       : request vector
//   advance   : a grant was taken this cycle; priority moves to the other side
//   grant     : one-hot (or zero) combinational grant
module axil_rr_arb2
   import axil_bram_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic prio_q;

   always_comb begin
      grant    = 2'b00;
      grant[0] = req[0] && (!req[1] || prio_q == PRIO_READ);
      grant[1] = req[1] && (!req[0] || prio_q == PRIO_WRITE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         prio_q <= PRIO_READ;
      end else if (advance) begin
         prio_q <= grant[0] ? PRIO_WRITE : PRIO_READ;
      end
   end

endmodule

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave to single-port BRAM bridge, one outstanding transaction.
//   clk, rstn  : clock, synchronous active-low reset
//   s_axi      : AXI4-Lite slave channels (axil_bram_bridge_if.slave)
//   bram_addr  : BRAM word address (byte address >> log2(DATA_W/8), truncated)
//   bram_din   : BRAM write data
//   bram_dout  : BRAM read data, valid RD_LAT edges after bram_en
//   bram_en    : single-cycle access enable
//   bram_we    : byte write enables, only non-zero in WR_ISSUE
// Out-of-range addresses never touch the BRAM and answer SLVERR (rdata = 0).
module axil_bram_bridge
   import axil_bram_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int BRAM_AW = 12,
   parameter int RD_LAT  = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   axil_bram_bridge_if.slave    s_axi,
   output logic [BRAM_AW-1:0]   bram_addr,
   output logic [DATA_W-1:0]    bram_din,
   input  logic [DATA_W-1:0]    bram_dout,
   output logic                 bram_en,
   output logic [DATA_W/8-1:0]  bram_we
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = clog2(STRB_W);
   localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

   state_t              state_q, state_d;
   logic [1:0]          req, grant;
   logic [ADDR_W-1:0]   sel_addr, lat_word;
   logic                lat_oor;
   logic [BRAM_AW-1:0]  addr_q;
   logic                oor_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic [2:0]          cnt_q;
   logic                rvalid_q, bvalid_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [1:0]          rresp_q, bresp_q;

   // Only IDLE presents requests, so a grant is also the AR/AW handshake.
   assign req = (state_q == IDLE) ? {s_axi.awvalid, s_axi.arvalid} : 2'b00;

   axil_rr_arb2 u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req),
      .advance (|grant),
      .grant   (grant)
   );

   // Word index of the granted address; any bit above BRAM_AW means out of range.
   assign sel_addr = grant[0] ? s_axi.araddr : s_axi.awaddr;
   assign lat_word = sel_addr >> OFF_W;
   assign lat_oor  = |(lat_word >> BRAM_AW);

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      s_axi.arready  = 1'b0;
      s_axi.awready  = 1'b0;
      s_axi.wready   = 1'b0;
      bram_en        = 1'b0;
      bram_we        = '0;
      case (state_q)
         IDLE: begin
            s_axi.arready = grant[0];
            s_axi.awready = grant[1];
            // W is only taken together with its AW, never ahead of it.
            s_axi.wready  = grant[1] && s_axi.wvalid;
            if (grant[0])      state_d = RD_WAIT;
            else if (grant[1]) state_d = s_axi.wvalid ? WR_ISSUE : WR_DATA;
         end
         RD_WAIT: begin
            bram_en = (cnt_q == 3'd0) && !oor_q;
            if (cnt_q == LAT_LAST) state_d = RD_RESP;
         end
         RD_RESP: begin
            if (s_axi.rready) state_d = IDLE;
         end
         WR_DATA: begin
            s_axi.wready = 1'b1;
            if (s_axi.wvalid) state_d = WR_ISSUE;
         end
         WR_ISSUE: begin
            bram_en = !oor_q;
            bram_we = oor_q ? '0 : wstrb_q;
            state_d = WR_RESP;
         end
         WR_RESP: begin
            if (s_axi.bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_q   <= '0;
         oor_q    <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         if (state_q == IDLE && |grant) begin
            addr_q <= lat_word[BRAM_AW-1:0];
            oor_q  <= lat_oor;
         end
         if (s_axi.wready && s_axi.wvalid) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
         end
         // Counts edges since bram_en; at RD_LAT the BRAM output is valid.
         cnt_q <= (state_q == RD_WAIT) ? cnt_q + 3'd1 : 3'd0;
         if (state_q == RD_WAIT && cnt_q == LAT_LAST) begin
            rvalid_q <= 1'b1;
            rdata_q  <= oor_q ? '0 : bram_dout;
            rresp_q  <= oor_q ? RESP_SLVERR : RESP_OKAY;
         end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
         end
         if (state_q == WR_ISSUE) begin
            bvalid_q <= 1'b1;
            bresp_q  <= oor_q ? RESP_SLVERR : RESP_OKAY;
         end else if (bvalid_q && s_axi.bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   assign s_axi.rvalid = rvalid_q;
   assign s_axi.rdata  = rdata_q;
   assign s_axi.rresp  = rresp_q;
   assign s_axi.bvalid = bvalid_q;
   assign s_axi.bresp  = bresp_q;
   assign bram_addr    = addr_q;
   assign bram_din     = wdata_q;

endmodule

// File: tb/tb_axil_bram_bridge.sv
// Bench for axil_bram_bridge: directed scenarios plus randomized traffic,
// checked against an array-based memory/priority reference model.
module tb_axil_bram_bridge;
   import axil_bram_pkg::*;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int BRAM_AW = 12;
   localparam int RD_LAT  = 2;
   localparam int DEPTH   = 1 << BRAM_AW;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   axil_bram_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s_axi ();

   logic [BRAM_AW-1:0] bram_addr;
   logic [DATA_W-1:0]  bram_din, bram_dout;
   logic               bram_en;
   logic [3:0]         bram_we;

   axil_bram_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BRAM_AW(BRAM_AW), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .s_axi     (s_axi.slave),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .bram_dout (bram_dout),
      .bram_en   (bram_en),
      .bram_we   (bram_we)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM behavioural model: read-first, RD_LAT edges from enable to data.
   bit [31:0] mem [DEPTH];
   logic [31:0] pipe [RD_LAT];
   always @(posedge clk) begin
      if (bram_en) begin
         pipe[0] <= mem[bram_addr];
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
      end
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bram_dout = pipe[RD_LAT-1];

   // Bus-side activity recorder.
   int en_cnt = 0, en_cyc = 0, we_cnt = 0, we_cyc = 0, wr_cnt = 0, wr_last = 0;
   logic [BRAM_AW-1:0] en_addr = '0;
   logic [3:0] we_val = '0;
   always @(negedge clk) begin
      if (bram_en) begin en_cnt++; en_cyc = cyc; en_addr = bram_addr; end
      if (bram_we != 4'd0) begin we_cnt++; we_cyc = cyc; we_val = bram_we; end
      if (s_axi.wready) begin wr_cnt++; wr_last = cyc; end
   end

   // Reference model.
   bit [31:0] ref_mem [DEPTH];
   bit        exp_prio = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >> 2) < DEPTH;
   endfunction

   task automatic model(input bit do_rd, input logic [31:0] raddr, input bit do_wr,
                        input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic [31:0] er, output logic [1:0] err, output logic [1:0] ebr,
                        output int efirst);
      int last;
      efirst = (do_rd && do_wr) ? (exp_prio ? 2 : 1) : (do_rd ? 1 : 2);
      er = '0; err = 2'b00; ebr = 2'b00;
      for (int step = 0; step < 2; step++) begin
         int who;
         who = (step == 0) ? efirst : 3 - efirst;
         if (who == 1 && do_rd) begin
            er  = in_rng(raddr) ? ref_mem[raddr >> 2] : 32'h0;
            err = in_rng(raddr) ? 2'b00 : 2'b10;
         end
         if (who == 2 && do_wr) begin
            ebr = in_rng(waddr) ? 2'b00 : 2'b10;
            if (in_rng(waddr))
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) ref_mem[waddr >> 2][8*b +: 8] = wdata[8*b +: 8];
         end
      end
      last = (do_rd && do_wr) ? 3 - efirst : efirst;
      exp_prio = (last == 1);
   endtask

   logic [31:0] g_rdata;
   logic [1:0]  g_rresp, g_bresp;
   int g_ar_cyc, g_aw_cyc, g_w_cyc, g_rv_cyc, g_bv_cyc, g_first;
   bit g_unstable, g_w_early;

   task automatic xact(input bit do_rd, input logic [31:0] raddr, input bit do_wr,
                       input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input int w_delay, input int rr_delay);
      bit ar_d, aw_d, w_d, r_d, b_d;
      int rv_n;
      ar_d = !do_rd; r_d = !do_rd; aw_d = !do_wr; w_d = !do_wr; b_d = !do_wr;
      rv_n = 0; g_first = 0; g_unstable = 0; g_w_early = 0;
      g_rdata = '0; g_rresp = '0; g_bresp = '0;
      for (int k = 0; k < 80 && !(r_d && b_d); k++) begin
         @(posedge clk); #1;
         s_axi.arvalid = !ar_d; s_axi.araddr = raddr;
         s_axi.awvalid = !aw_d; s_axi.awaddr = waddr;
         s_axi.wvalid  = !w_d && (k >= w_delay);
         s_axi.wdata   = wdata; s_axi.wstrb = wstrb;
         s_axi.rready  = (rv_n >= rr_delay);
         s_axi.bready  = 1'b1;
         @(negedge clk);
         if (s_axi.wready && !(aw_d && do_wr) && !s_axi.awready) g_w_early = 1;
         if (!r_d && ar_d) begin
            if (s_axi.rvalid) begin
               if (rv_n == 0) begin
                  g_rv_cyc = cyc; g_rdata = s_axi.rdata; g_rresp = s_axi.rresp;
               end else if (s_axi.rdata !== g_rdata || s_axi.rresp !== g_rresp) g_unstable = 1;
               rv_n++;
               if (s_axi.rready) r_d = 1;
            end else if (rv_n > 0) g_unstable = 1;
         end
         if (!b_d && aw_d && s_axi.bvalid) begin
            g_bv_cyc = cyc; g_bresp = s_axi.bresp; b_d = 1;
         end
         if (s_axi.arvalid && s_axi.arready) begin
            ar_d = 1; g_ar_cyc = cyc; if (g_first == 0) g_first = 1;
         end
         if (s_axi.awvalid && s_axi.awready) begin
            aw_d = 1; g_aw_cyc = cyc; if (g_first == 0) g_first = 2;
         end
         if (s_axi.wvalid && s_axi.wready) begin w_d = 1; g_w_cyc = cyc; end
      end
      chk("xact_complete", {r_d, b_d}, 2'b11);
      chk("w_before_aw", g_w_early, 0);
      chk("r_hold_stable", g_unstable, 0);
      @(posedge clk); #1;
      s_axi.arvalid = 0; s_axi.awvalid = 0; s_axi.wvalid = 0;
      s_axi.rready = 0; s_axi.bready = 0;
   endtask

   task automatic run_check(input string tag, input bit do_rd, input logic [31:0] raddr,
                            input bit do_wr, input logic [31:0] waddr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int w_delay, input int rr_delay);
      logic [31:0] er; logic [1:0] err, ebr; int efirst;
      model(do_rd, raddr, do_wr, waddr, wdata, wstrb, er, err, ebr, efirst);
      xact(do_rd, raddr, do_wr, waddr, wdata, wstrb, w_delay, rr_delay);
      if (do_rd) begin
         chk({tag, "_rdata"}, g_rdata, er);
         chk({tag, "_rresp"}, g_rresp, err);
      end
      if (do_wr) chk({tag, "_bresp"}, g_bresp, ebr);
      if (do_rd && do_wr) chk({tag, "_grant_order"}, g_first, efirst);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ctl"}, {s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid, s_axi.rresp,
                          s_axi.bvalid, s_axi.bresp, bram_en, bram_we}, 64'd0);
      chk({tag, "_rdata"}, s_axi.rdata, 64'd0);
      chk({tag, "_bram_addr"}, bram_addr, 64'd0);
      chk({tag, "_bram_din"}, bram_din, 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rstn = 0;
      s_axi.arvalid = 0; s_axi.awvalid = 0; s_axi.wvalid = 0;
      s_axi.rready = 0; s_axi.bready = 0;
      @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk); #1;
      rstn = 1;
      exp_prio = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, w0, wc0, op;
      bit saw_rvalid;
      logic [31:0] a, b;
      s_axi.araddr = '0; s_axi.arvalid = 0; s_axi.rready = 0;
      s_axi.awaddr = '0; s_axi.awvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0;
      s_axi.wvalid = 0; s_axi.bready = 0;
      repeat (2) @(posedge clk);
      do_reset();
      @(negedge clk);
      chk_outputs_zero("post_reset");

      // 1: write then read back, read latency and word address
      run_check("t1_wr", 0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      chk("t1_wr_bram_addr", en_addr, 4);
      run_check("t1_rd", 1, 32'h10, 0, 0, 0, 0, 0, 0);
      chk("t1_rd_bram_addr", en_addr, 4);
      chk("t1_en_cycle", en_cyc - g_ar_cyc, 1);
      chk("t1_rvalid_cycle", g_rv_cyc - g_ar_cyc, RD_LAT + 2);
      chk("t1_rdata_const", g_rdata, 32'hDEADBEEF);

      // 2: simultaneous AR/AW, round-robin
      do_reset();
      run_check("t2a", 1, 32'h100, 1, 32'h104, 32'h11112222, 4'hF, 0, 0);
      chk("t2a_read_first", g_first, 1);
      run_check("t2_single", 1, 32'h104, 0, 0, 0, 0, 0, 0);
      run_check("t2b", 1, 32'h108, 1, 32'h108, 32'h33334444, 4'hF, 0, 0);
      chk("t2b_write_first", g_first, 2);

      // 3: W three cycles after AW
      wc0 = wr_cnt;
      run_check("t3", 0, 0, 1, 32'h20, 32'hA5A55A5A, 4'hF, 3, 0);
      chk("t3_w_cycle", g_w_cyc - g_aw_cyc, 3);
      chk("t3_wready_cycles", wr_cnt - wc0, 3);
      chk("t3_wready_last", wr_last - g_aw_cyc, 3);
      chk("t3_we_cycle", we_cyc - g_aw_cyc, 4);
      chk("t3_we_value", we_val, 4'hF);
      chk("t3_bvalid_cycle", g_bv_cyc - g_aw_cyc, 5);

      // 4: out-of-range read and write
      e0 = en_cnt; w0 = we_cnt;
      run_check("t4_rd", 1, 32'h4000, 0, 0, 0, 0, 0, 0);
      chk("t4_rd_no_en", en_cnt - e0, 0);
      chk("t4_rresp_const", g_rresp, 2'b10);
      run_check("t4_wr", 0, 0, 1, 32'h4000, 32'h12345678, 4'hF, 1, 0);
      chk("t4_wr_no_en", en_cnt - e0, 0);
      chk("t4_wr_no_we", we_cnt - w0, 0);

      // 5: partial strobes over a cleared word
      run_check("t5_wr", 0, 0, 1, 32'h40, 32'hFFFFFFFF, 4'b0101, 0, 0);
      chk("t5_we_value", we_val, 4'b0101);
      run_check("t5_rd", 1, 32'h40, 0, 0, 0, 0, 0, 0);
      chk("t5_rdata_const", g_rdata, 32'h00FF00FF);

      // 6: rready held off, then reset in the middle of a read
      run_check("t6_hold", 1, 32'h10, 0, 0, 0, 0, 0, 10);
      @(posedge clk); #1;
      s_axi.arvalid = 1; s_axi.araddr = 32'h10;
      @(negedge clk);
      chk("t6_arready", s_axi.arready, 1);
      @(posedge clk); #1;
      s_axi.arvalid = 0;
      rstn = 0;
      @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("t6_mid_reset");
      @(posedge clk); #1;
      rstn = 1;
      exp_prio = 1'b0;
      saw_rvalid = 0;
      repeat (6) begin
         @(negedge clk);
         if (s_axi.rvalid) saw_rvalid = 1;
      end
      chk("t6_aborted_no_resp", saw_rvalid, 0);
      run_check("t6_after", 1, 32'h10, 0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 2);
         a = ($urandom_range(0, 7) == 0) ? 32'h4000 + 32'($urandom_range(0, 255)) * 4
                                         : 32'($urandom_range(0, 15)) * 4;
         a = a | 32'($urandom_range(0, 3));
         b = ($urandom_range(0, 7) == 0) ? 32'h8000 + 32'($urandom_range(0, 255)) * 4
                                         : 32'($urandom_range(0, 15)) * 4;
         run_check("rnd", op != 1, a, op != 0, b, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
